// File: rtl/cnt_share_arb_pkg.sv
// Shared types and defaults for the round-robin counter-sharing scheduler.
package cnt_share_arb_pkg;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        UPDATE = 2'd2,
        ACK    = 2'd3
    } state_e;

    // Index width for a requester number; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnt_share_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping.
module rr_pick
    import cnt_share_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    localparam logic [NREQ-1:0] ONE_LSB = {{(NREQ-1){1'b0}}, 1'b1};

    logic [IW-1:0] cand_s;

    // Walk candidates from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx    = {IW{1'b0}};
        cand_s = {IW{1'b0}};
        any    = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_s = IW'((int'(ptr) + k) % NREQ);
            idx    = req[cand_s] ? cand_s : idx;
        end
        gnt = any ? (ONE_LSB << idx) : {NREQ{1'b0}};
    end

endmodule

// File: rtl/cnt_share_arb.sv
// Round-robin scheduler sharing one counter/adder between NREQ requesters.
// Each grant runs GRANT -> UPDATE -> ACK and adds op_a + op_b (0..2) of the winner.
module cnt_share_arb
    import cnt_share_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  op_a,
    input  logic [NREQ-1:0]  op_b,
    input  logic             clr,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  ack,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             busy
);

    localparam int IW = idx_width(NREQ);
    localparam logic [NREQ-1:0] ONE_LSB = {{(NREQ-1){1'b0}}, 1'b1};

    state_e           state_r, state_s;
    logic [IW-1:0]    ptr_r, ptr_s, win_r, win_s;
    logic             opa_r, opa_s, opb_r, opb_s;
    logic [WIDTH-1:0] cnt_r, cnt_s;
    logic             wrap_r, wrap_s, busy_r, busy_s;
    logic [NREQ-1:0]  gnt_r, gnt_s, ack_r, ack_s;
    logic [NREQ-1:0]  pick_gnt_s;
    logic [IW-1:0]    pick_idx_s;
    logic             pick_any_s;
    logic [WIDTH:0]   sum_s;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req (req),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // One extra bit so the carry out of the counter becomes the wrap pulse.
    assign sum_s = {1'b0, cnt_r} + {{WIDTH{1'b0}}, opa_r} + {{WIDTH{1'b0}}, opb_r};

    // Next-state logic; clr in IDLE takes precedence over any request.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (clr) begin
                    state_s = IDLE;
                end else if (pick_any_s) begin
                    state_s = GRANT;
                end else begin
                    state_s = IDLE;
                end
            end
            GRANT:   state_s = UPDATE;
            UPDATE:  state_s = ACK;
            ACK:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of every registered output and internal register.
    always_comb begin
        ptr_s  = ptr_r;
        win_s  = win_r;
        opa_s  = opa_r;
        opb_s  = opb_r;
        cnt_s  = cnt_r;
        gnt_s  = gnt_r;
        ack_s  = {NREQ{1'b0}};
        wrap_s = 1'b0;
        busy_s = (state_s != IDLE);
        case (state_r)
            IDLE: begin
                if (clr) begin
                    cnt_s = {WIDTH{1'b0}};
                end else if (pick_any_s) begin
                    gnt_s = pick_gnt_s;
                    win_s = pick_idx_s;
                    ptr_s = (pick_idx_s == IW'(NREQ - 1)) ? {IW{1'b0}} : pick_idx_s + IW'(1);
                end else begin
                    gnt_s = {NREQ{1'b0}};
                end
            end
            GRANT: begin
                opa_s = op_a[win_r];
                opb_s = op_b[win_r];
            end
            UPDATE: begin
                cnt_s  = sum_s[WIDTH-1:0];
                wrap_s = sum_s[WIDTH];
                ack_s  = ONE_LSB << win_r;
                gnt_s  = {NREQ{1'b0}};
            end
            ACK: begin
                gnt_s = {NREQ{1'b0}};
            end
            default: begin
                gnt_s = {NREQ{1'b0}};
            end
        endcase
    end

    // State and output registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            ptr_r   <= {IW{1'b0}};
            win_r   <= {IW{1'b0}};
            opa_r   <= 1'b0;
            opb_r   <= 1'b0;
            cnt_r   <= {WIDTH{1'b0}};
            wrap_r  <= 1'b0;
            busy_r  <= 1'b0;
            gnt_r   <= {NREQ{1'b0}};
            ack_r   <= {NREQ{1'b0}};
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            win_r   <= win_s;
            opa_r   <= opa_s;
            opb_r   <= opb_s;
            cnt_r   <= cnt_s;
            wrap_r  <= wrap_s;
            busy_r  <= busy_s;
            gnt_r   <= gnt_s;
            ack_r   <= ack_s;
        end
    end

    assign gnt  = gnt_r;
    assign ack  = ack_r;
    assign cnt  = cnt_r;
    assign wrap = wrap_r;
    assign busy = busy_r;

endmodule

// File: doc/cnt_share_arb.md
# cnt_share_arb

Round-robin scheduler that shares one WIDTH-bit counter/adder datapath between NREQ requesters. Each requester presents two 1-bit operands; the block grants one requester at a time, adds the zero-extended 2-bit operand sum (0..2) to the shared counter, and acknowledges completion. It sits between the requesting sub-blocks and the shared count register, replacing free-running increment-by-one counting with arbitrated, variable increments.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, shared counter width (≥2)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- req  in  NREQ  per-requester request level
- op_a  in  NREQ  operand a, bit i belongs to requester i
- op_b  in  NREQ  operand b, bit i belongs to requester i
- clr  in  1  synchronous counter clear request
- gnt  out  NREQ  one-hot grant, registered
- ack  out  NREQ  one-hot single-cycle completion pulse, registered
- cnt  out  WIDTH  shared counter value, registered
- wrap  out  1  single-cycle pulse: last update carried out of bit WIDTH-1
- busy  out  1  high whenever FSM is not IDLE

## Operation
- FSM states: IDLE, GRANT, UPDATE, ACK.
- IDLE: if clr=1 -> cnt<=0, stay IDLE (clr beats req). Else if any req -> pick winner, gnt<=onehot(winner), go GRANT. Else stay.
- GRANT: latch op_a[w], op_b[w] of winner w into operand register; go UPDATE.
- UPDATE: cnt <= cnt + {0,op_a}+{0,op_b} computed at WIDTH+1 bits; cnt takes low WIDTH bits, wrap<=bit WIDTH; go ACK.
- ACK: ack[w]<=1 for this cycle only, gnt<=0; go IDLE.
- Winner: first asserted req at or after priority pointer ptr, searching upward modulo NREQ. After each grant ptr<=w+1 mod NREQ. ptr resets to 0.
- Requester rule: hold req and operands from assertion until ack seen; may deassert req in the cycle after ack or keep it for another transaction. Operands are sampled only in GRANT; later changes have no effect.
- req dropped after grant: transaction still completes (no abort).
- clr outside IDLE: ignored; requester of clr must hold it until IDLE.
- Arithmetic: increment 0..2, unsigned, modulo 2^WIDTH; op_a=op_b=0 still costs a full transaction (ack issued, cnt unchanged, wrap=0).
- Reset (any time, including mid-transaction): state IDLE, gnt=0, ack=0, cnt=0, wrap=0, busy=0, ptr=0, operand register=0; in-flight transaction is discarded with no ack.

## Timing
- Cycle 0: req sampled in IDLE. Cycle 1: gnt high, state GRANT. Cycle 2: state UPDATE. Cycle 3: cnt and wrap show new value, ack high, gnt low. Cycle 4: IDLE; next grant visible at cycle 5 earliest.
- Throughput: one transaction per 4 cycles; gnt high for exactly 2 cycles (GRANT, UPDATE).
- wrap and ack are high in the same cycle, one cycle each.
- busy = (state != IDLE), registered with state.
- No combinational path from any input to any output.

## Structure
- Package cnt_share_arb_pkg: state enum (IDLE, GRANT, UPDATE, ACK), default NREQ/WIDTH constants.
- Sub-module rr_pick: combinational round-robin picker (inputs req, ptr; outputs one-hot grant, index, any). Top holds FSM, ptr, operand register, counter.

## Test plan
- Reset then single req[0] with op_a=1, op_b=1 -> gnt[0] cycles 1-2, ack[0] cycle 3, cnt=2, wrap=0.
- All four req held, operands 1/0 each -> grant order 0,1,2,3,0; each ack one cycle; cnt increments by 1 per transaction, 4 cycles apart.
- cnt preloaded to 255 via updates, then request with op_a=op_b=1 -> cnt=1, wrap=1 same cycle as ack.
- clr and req[2] both high in IDLE -> cnt=0, no gnt that cycle, grant to 2 next cycle; clr pulsed during UPDATE -> ignored.
- rst low during UPDATE -> all outputs zero immediately, no ack; after release req[1] served first with ptr=0 search.
- Operands changed after GRANT -> cnt reflects sampled operands only.
